// File: rtl/rns_crt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rns_crt_sequencer
// Purpose  : Sequential 3-channel RNS-to-binary CRT converter with iterative
//            modular-inverse search; optional inverse cache (RNS_SEQ_INV_CACHE_EN).
// Revision : 1.0
// ============================================================================
module rns_crt_sequencer #(
  parameter int RES_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RES_W-1:0]   residue1,
  input  logic [RES_W-1:0]   residue2,
  input  logic [RES_W-1:0]   residue3,
  input  logic [RES_W-1:0]   moduli1,
  input  logic [RES_W-1:0]   moduli2,
  input  logic [RES_W-1:0]   moduli3,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3*RES_W-1:0] binary,
  output logic               err,
  output logic               busy
);

  localparam int C_PROD_W = 2 * RES_W;
  localparam int C_FULL_W = 3 * RES_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PROD = 3'd1,
    S_INV  = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                    r_state;
  logic [2:0][RES_W-1:0]     r_res;
  logic [2:0][RES_W-1:0]     r_mod;
  logic [2:0][RES_W-1:0]     r_inv;
  logic [2:0][C_PROD_W-1:0]  r_prod;
  logic [C_FULL_W-1:0]       r_mtot;
  logic [C_FULL_W-1:0]       r_acc;
  logic [1:0]                r_idx;
  logic [RES_W-1:0]          r_k;
  logic [RES_W-1:0]          r_t;
  logic [RES_W-1:0]          r_step;
  logic                      r_err;

  logic [2:0][C_PROD_W-1:0]  w_prod;
  logic [C_FULL_W-1:0]       w_mtot;
  logic [C_FULL_W-1:0]       w_term;
  logic [C_FULL_W-1:0]       w_acc_next;
  logic [C_FULL_W:0]         w_sum;
  logic [1:0]                w_sel;
  logic [RES_W-1:0]          w_seed_div;
  logic [RES_W-1:0]          w_seed;
  logic [RES_W-1:0]          w_acc_div;
  logic [RES_W-1:0]          w_rk;
  logic [RES_W-1:0]          w_t_next;
  logic [RES_W:0]            w_t_add;
  logic [RES_W:0]            w_k_inc;
  logic                      w_bad;

  assign w_prod[0] = C_PROD_W'(r_mod[1]) * C_PROD_W'(r_mod[2]);
  assign w_prod[1] = C_PROD_W'(r_mod[0]) * C_PROD_W'(r_mod[2]);
  assign w_prod[2] = C_PROD_W'(r_mod[0]) * C_PROD_W'(r_mod[1]);
  assign w_mtot    = C_FULL_W'(w_prod[0]) * C_FULL_W'(r_mod[0]);
  assign w_bad     = (r_mod[0] < RES_W'(2)) || (r_mod[1] < RES_W'(2)) || (r_mod[2] < RES_W'(2));

  // Seed channel: channel 1 when leaving PROD, otherwise the channel after the current one.
  assign w_sel      = (r_state == S_INV && r_idx != 2'd2) ? r_idx + 2'd1 : 2'd0;
  assign w_seed_div = (r_mod[w_sel] == '0) ? RES_W'(1) : r_mod[w_sel];
  assign w_seed     = RES_W'(w_prod[w_sel] % C_PROD_W'(w_seed_div));

  assign w_t_add  = {1'b0, r_t} + {1'b0, r_step};
  assign w_t_next = RES_W'((w_t_add >= {1'b0, r_mod[r_idx]}) ? w_t_add - {1'b0, r_mod[r_idx]} : w_t_add);
  assign w_k_inc  = {1'b0, r_k} + {{RES_W{1'b0}}, 1'b1};

  assign w_acc_div  = (r_mod[r_idx] == '0) ? RES_W'(1) : r_mod[r_idx];
  assign w_rk       = RES_W'((C_PROD_W'(r_res[r_idx]) * C_PROD_W'(r_inv[r_idx])) % C_PROD_W'(w_acc_div));
  assign w_term     = C_FULL_W'(r_prod[r_idx]) * C_FULL_W'(w_rk);
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_term};
  assign w_acc_next = C_FULL_W'((w_sum >= {1'b0, r_mtot}) ? w_sum - {1'b0, r_mtot} : w_sum);

`ifdef RNS_SEQ_INV_CACHE_EN
  logic                  r_cache_valid;
  logic [2:0][RES_W-1:0] r_cache_mod;
  logic [2:0][RES_W-1:0] r_cache_inv;
  logic                  w_cache_hit;

  assign w_cache_hit = r_cache_valid && (r_cache_mod == r_mod);

  // Only the last ACC step is ever reached error-free, so it is the commit point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cache_valid <= 1'b0;
      r_cache_mod   <= '0;
      r_cache_inv   <= '0;
    end else if (r_state == S_ACC && r_idx == 2'd2) begin
      r_cache_valid <= 1'b1;
      r_cache_mod   <= r_mod;
      r_cache_inv   <= r_inv;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_res     <= '0;
      r_mod     <= '0;
      r_inv     <= '0;
      r_prod    <= '0;
      r_mtot    <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_k       <= '0;
      r_t       <= '0;
      r_step    <= '0;
      r_err     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      binary    <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_res    <= {residue3, residue2, residue1};
            r_mod    <= {moduli3, moduli2, moduli1};
            r_acc    <= '0;
            r_idx    <= '0;
            r_err    <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_PROD;
          end
        end
        S_PROD: begin
          r_prod <= w_prod;
          r_mtot <= w_mtot;
          if (w_bad) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end
`ifdef RNS_SEQ_INV_CACHE_EN
          else if (w_cache_hit) begin
            r_inv   <= r_cache_inv;
            r_state <= S_ACC;
          end
`endif
          else begin
            r_k     <= RES_W'(1);
            r_t     <= w_seed;
            r_step  <= w_seed;
            r_state <= S_INV;
          end
        end
        S_INV: begin
          // r_t tracks k*(Mi mod mi) mod mi, so a hit means k is the inverse.
          if (r_t == RES_W'(1)) begin
            r_inv[r_idx] <= r_k;
            r_k          <= RES_W'(1);
            r_t          <= w_seed;
            r_step       <= w_seed;
            if (r_idx == 2'd2) begin
              r_idx   <= '0;
              r_state <= S_ACC;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end else if (w_k_inc == {1'b0, r_mod[r_idx]}) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + RES_W'(1);
            r_t <= w_t_next;
          end
        end
        S_ACC: begin
          r_acc <= w_acc_next;
          if (r_idx == 2'd2) begin
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        S_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            binary    <= r_err ? '0 : r_acc;
            err       <= r_err;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rns_crt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rns_crt_sequencer
// Purpose  : Scoreboard bench for rns_crt_sequencer with directed CRT vectors.
// Revision : 1.0
// ============================================================================
module tb_rns_crt_sequencer;

  localparam int RES_W    = 3;
  localparam int C_FULL_W = 3 * RES_W;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [RES_W-1:0]    residue1 = '0;
  logic [RES_W-1:0]    residue2 = '0;
  logic [RES_W-1:0]    residue3 = '0;
  logic [RES_W-1:0]    moduli1 = '0;
  logic [RES_W-1:0]    moduli2 = '0;
  logic [RES_W-1:0]    moduli3 = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [C_FULL_W-1:0] binary;
  logic                err;
  logic                busy;

  rns_crt_sequencer #(.RES_W(RES_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .residue1  (residue1),
    .residue2  (residue2),
    .residue3  (residue3),
    .moduli1   (moduli1),
    .moduli2   (moduli2),
    .moduli3   (moduli3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .binary    (binary),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int err;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  exp_t cur;
  bit   have_cur = 0;
  bit   cur_skip = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_acc = -1;
  int   last_hs = -1;
  bit   c_valid = 0;
  int   c_m1 = 0, c_m2 = 0, c_m3 = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: timestamps input handshakes and scores each presented result.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      acc_q.delete();
      have_cur = 0;
    end else begin
      if (in_valid && in_ready) begin
        acc_q.push_back(cyc + 1);
        last_acc = cyc + 1;
      end
      if (out_valid) begin
        if (!have_cur) begin
          have_cur = 1;
          if (exp_q.size() == 0) begin
            cur_skip = 1;
            check("unexpected_out_valid", 1, 0);
          end else begin
            int t0;
            cur      = exp_q.pop_front();
            cur_skip = 0;
            t0       = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
            check("latency", cyc - t0, cur.lat);
            check("binary", int'(binary), cur.bin);
            check("err", int'(err), cur.err);
            check("busy_in_done", int'(busy), 1);
            check("in_ready_in_done", int'(in_ready), 0);
          end
        end else if (!cur_skip) begin
          check("hold_binary", int'(binary), cur.bin);
          check("hold_err", int'(err), cur.err);
        end
        if (out_ready) begin
          have_cur = 0;
          last_hs  = cyc + 1;
        end
      end
    end
  end

  task automatic send(input int r1, input int r2, input int r3,
                      input int m1, input int m2, input int m3,
                      input int ebin, input int eerr, input int full_lat, input bit track);
    exp_t e;
    bit   ok;
    ok = 0;
    if (track) begin
      e.bin = ebin;
      e.err = eerr;
      e.lat = full_lat;
`ifdef RNS_SEQ_INV_CACHE_EN
      if (eerr == 0 && c_valid && c_m1 == m1 && c_m2 == m2 && c_m3 == m3) e.lat = 5;
`endif
      if (eerr == 0) begin
        c_valid = 1;
        c_m1 = m1;
        c_m2 = m2;
        c_m3 = m3;
      end
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    residue1 = RES_W'(r1);
    residue2 = RES_W'(r2);
    residue3 = RES_W'(r3);
    moduli1  = RES_W'(m1);
    moduli2  = RES_W'(m2);
    moduli3  = RES_W'(m3);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (ok) check("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid && !have_cur) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 0, 1);
  endtask

  initial begin
    bit stall_ok;
    bit got;
    bit saw;
    repeat (3) @(posedge clk); #1;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_binary", int'(binary), 0);
    check("reset_err", int'(err), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;

    send(1, 2, 3, 3, 5, 7, 52, 0, 9, 1);   wait_idle();
    send(1, 2, 3, 3, 5, 7, 52, 0, 9, 1);   wait_idle();
    send(4, 5, 6, 5, 6, 7, 209, 0, 17, 1); wait_idle();
    send(1, 1, 1, 2, 4, 7, 0, 1, 3, 1);    wait_idle();
    send(1, 1, 1, 1, 5, 7, 0, 1, 2, 1);    wait_idle();

    // Output stall with a second operand set already waiting.
    out_ready = 1'b0;
    send(1, 1, 1, 5, 6, 7, 1, 0, 17, 1);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        break;
      end
    end
    check("stall_out_valid_seen", int'(got), 1);
    stall_ok = 1;
    fork
      send(2, 4, 6, 3, 5, 7, 104, 0, 9, 1);
      begin
        repeat (20) begin
          @(negedge clk);
          if (in_ready) stall_ok = 0;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    check("in_ready_low_in_stall", int'(stall_ok), 1);
    check("b2b_accept_cycle", last_acc, last_hs + 1);
    wait_idle();

    // Abort mid inverse search with an asynchronous reset.
    send(1, 1, 1, 5, 6, 7, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_binary", int'(binary), 0);
    check("abort_err", int'(err), 0);
    check("abort_busy", int'(busy), 0);
    repeat (2) @(posedge clk); #1;
    rst_n   = 1'b1;
    c_valid = 0;
    saw = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    check("no_stale_out_valid", int'(saw), 0);

    send(7, 7, 7, 3, 5, 7, 7, 0, 9, 1); wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/rns_crt_sequencer.md
# rns_crt_sequencer

Sequential Chinese-Remainder-Theorem converter turning a three-channel RNS word (residues plus run-time moduli) into binary. It sits at the output of the RNS datapath, in place of a fully combinational RNS-to-binary converter. It time-shares one small multiply/reduce unit across the three channels and searches modular inverses iteratively. Input and output use valid/ready handshakes.

## Interface
- RES_W, 3, width of each residue and modulus; M = m1*m2*m3 fits in 3*RES_W bits
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand set present
- in_ready  out  1  high only in IDLE; transfer on in_valid & in_ready
- residue1..residue3  in  RES_W each  RNS digits
- moduli1..moduli3  in  RES_W each  moduli; must be pairwise coprime and >= 2
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts; transfer on out_valid & out_ready
- binary  out  3*RES_W  CRT result in [0, M-1]; 0 on error
- err  out  1  conversion failed (modulus < 2 or no inverse exists)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, PROD, INV, ACC, DONE.
- IDLE: in_ready=1. On handshake, latch all six operands, clear acc and index, go to PROD.
- PROD (1 cycle):
  - Compute M, M1=m2*m3, M2=m1*m3, M3=m1*m2.
  - If any mi < 2, set err and go to DONE. Otherwise go to INV with i=1, k=1, t=Mi mod mi.
- INV (one candidate per cycle):
  - If t==1, store inv_i=k. Advance to i+1 with k=1 and t=M(i+1) mod m(i+1). After i=3, go to ACC.
  - Otherwise set k=k+1 and t=t+(Mi mod mi); subtract mi if t >= mi.
  - If k reaches mi without a hit, set err and go to DONE.
  - A channel therefore costs exactly inv_i cycles.
- ACC (3 cycles, i=1..3):
  - Each cycle: term = Mi * ((ri*inv_i) mod mi), then acc = acc + term, minus M if the sum >= M.
  - acc stays < M throughout. After i=3, go to DONE.
  - Residues >= mi are reduced implicitly by the mod.
- DONE:
  - out_valid=1; binary=acc (or 0 if err); err as computed. Outputs hold stable until out_ready.
  - On the output handshake, go to IDLE. in_ready stays 0 in that same cycle, so back-to-back input is accepted no earlier than the next cycle.
- Reset values: in_ready=1, out_valid=0, binary=0, err=0, busy=0, state=IDLE, inverse cache invalid.
- Reset asserted mid-conversion aborts immediately. The partial result is discarded and no out_valid is produced.
- Only the mod-mi helpers (at most 2*RES_W by RES_W bits) are combinational.

## Timing
- Input handshake at edge T. out_valid rises at edge T+5+K, where K = inv_1+inv_2+inv_3.
- Moduli 3,5,7: inverses are 2,1,1, so K=4 and latency is 9 cycles.
- Error at PROD: out_valid rises at T+2.
- Error in INV: out_valid rises one cycle after the failing candidate k=mi-1.
- Throughput is bounded by the output handshake; out_ready held low stalls indefinitely in DONE.

## Configuration
- RNS_SEQ_INV_CACHE_EN defined:
  - Holds the last successful moduli triple and its three inverses.
  - If the latched moduli match a valid cache entry, PROD goes directly to ACC. Latency becomes 5 cycles.
  - The cache is written only on error-free completion and is invalidated by reset.
- RNS_SEQ_INV_CACHE_EN not defined: INV always runs. No cache registers are present.

## Test plan
- Moduli 3,5,7, residues 1,2,3, out_ready=1 -> binary=52, err=0, out_valid exactly 9 cycles after accept.
- Moduli 5,6,7, residues 4,5,6 -> binary=209 (M=210), err=0.
- Moduli 2,4,7 (not coprime) -> err=1, binary=0; moduli 1,5,7 -> err=1 with out_valid at T+2.
- out_ready held low 20 cycles -> binary/err stable, in_ready=0 throughout; new in_valid accepted only the cycle after the output handshake.
- Assert rst_n low during INV -> all outputs at reset values immediately; no stale out_valid after release.
- With RNS_SEQ_INV_CACHE_EN: two consecutive 3,5,7 conversions -> second latency 5 cycles with correct binary; a changed triple -> full latency.
